deser8: RTL

DESER8 -- requirements
Module: deser8

---
 rtl/deser8.sv | 134 +++++++++++++
 1 files changed

// File: rtl/deser8.sv
// Serial-to-parallel byte receiver with selectable bit order, rdy/vld handoff and sticky overrun.
// Optional even-parity bit after the data byte when DESER8_PARITY_EN is defined.
module deser8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       sd,
  input  logic       dir,
  input  logic       sync,
  input  logic       rdy,
  input  logic       clr,
  output logic [7:0] q,
  output logic       vld,
  output logic       ovr,
  output logic       perr,
  output logic       busy
);

`ifdef DESER8_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t     state;
  logic [7:0] sr;
  logic [3:0] cnt;
  logic       ldir;

  logic       done;
  logic [7:0] data;
  logic       overrun;
`ifdef DESER8_PARITY_EN
  logic       par_err;
`endif

  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in,
                                          input logic lsb_first);
    return lsb_first ? {bit_in, cur[7:1]} : {cur[6:0], bit_in};
  endfunction

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    done = 1'b0;
    data = shift_in(sr, sd, ldir);
`ifdef DESER8_PARITY_EN
    par_err = (^sr) ^ sd;
`endif
    if (en && !sync) begin
      case (state)
`ifdef DESER8_PARITY_EN
        PAR: begin
          done = 1'b1;
          data = sr;
        end
`else
        SHIFT: done = (cnt == 4'd7);
`endif
        default: done = 1'b0;
      endcase
    end
  end

  assign overrun = done && vld && !rdy;
  assign busy    = (state != IDLE);

`ifndef DESER8_PARITY_EN
  assign perr = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= 8'h00;
      cnt   <= 4'd0;
      ldir  <= 1'b0;
      q     <= 8'h00;
      vld   <= 1'b0;
      ovr   <= 1'b0;
`ifdef DESER8_PARITY_EN
      perr  <= 1'b0;
`endif
    end else begin
      // A sync (or idle) edge with en set starts a fresh frame with sd as its first bit.
      if (sync || state == IDLE) begin
        state <= IDLE;
        sr    <= 8'h00;
        cnt   <= 4'd0;
        if (en) begin
          state <= SHIFT;
          sr    <= shift_in(8'h00, sd, dir);
          ldir  <= dir;
          cnt   <= 4'd1;
        end
      end else if (en) begin
        case (state)
          SHIFT: begin
            sr <= data;
            if (cnt == 4'd7) begin
`ifdef DESER8_PARITY_EN
              cnt   <= 4'd8;
              state <= PAR;
`else
              cnt   <= 4'd0;
              state <= IDLE;
`endif
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: begin
            cnt   <= 4'd0;
            state <= IDLE;
          end
        endcase
      end

      if (done && (!vld || rdy)) begin
        q   <= data;
        vld <= 1'b1;
`ifdef DESER8_PARITY_EN
        perr <= par_err;
`endif
      end else if (rdy) begin
        vld <= 1'b0;
      end

      if (overrun) ovr <= 1'b1;
      else if (clr) ovr <= 1'b0;
    end
  end

endmodule
